// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the MAC-array sequencer, its datapath top and bench.
package matmul_pkg;

    localparam int N      = 8;   // matrix dimension = number of MAC lanes
    localparam int IDX_W  = 3;   // log2(N)
    localparam int ADDR_W = 6;   // 2*IDX_W, flat row*N+col address
    localparam int CNT_W  = 11;  // width of the run cycle counter

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/matmul_wr_scheduler.sv
// Result-RAM write-back scheduler: after each capture, walks the N buffered lanes
// of the captured column and emits one RAM write per cycle.
module matmul_wr_scheduler
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_i,
    input  logic [IDX_W-1:0]  j_prev_i,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_sel_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    logic             active_q, active_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] col_q, col_d;

    // Write-walk state register; reset drops any write still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            k_q      <= '0;
            col_q    <= '0;
        end else begin
            active_q <= active_d;
            k_q      <= k_d;
            col_q    <= col_d;
        end
    end

    // A new capture restarts the walk; it may coincide with the last write of the previous column.
    always_comb begin
        active_d = active_q;
        k_d      = k_q;
        col_d    = col_q;
        if (cap_i) begin
            active_d = 1'b1;
            k_d      = '0;
            col_d    = j_prev_i;
        end else if (active_q) begin
            if (k_q == IDX_W'(N - 1)) begin
                active_d = 1'b0;
                k_d      = '0;
            end else begin
                k_d = k_q + IDX_W'(1);
            end
        end
    end

    assign wr_en_o   = active_q;
    assign wr_sel_o  = active_q ? k_q : '0;
    assign wr_addr_o = active_q ? {k_q, col_q} : '0;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the N-lane MAC array computing C = A x B one column at a time:
// drives operand indices, MAC enable/clear, buffer capture and RAM write-back.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mac_en,
    output logic              mac_clear,
    output logic [IDX_W-1:0]  a_idx,
    output logic [ADDR_W-1:0] b_addr,
    output logic              cap,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CNT_W-1:0]  clock_count
);

    localparam logic [ADDR_W-1:0] RUN_LAST   = ADDR_W'(N * N - 1);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;   // flat step: low bits = t, high bits = j
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  t_w, j_w, j_prev;

    assign t_w = step_q[IDX_W-1:0];
    assign j_w = step_q[ADDR_W-1:IDX_W];

    // State, step and cycle-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control outputs; capture hands the column just finished to the scheduler.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        done      = 1'b0;
        mac_en    = 1'b0;
        mac_clear = 1'b0;
        a_idx     = '0;
        b_addr    = '0;
        cap       = 1'b0;
        j_prev    = '0;
        if (state_q != IDLE && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                busy      = 1'b1;
                mac_en    = 1'b1;
                a_idx     = t_w;
                b_addr    = {t_w, j_w};
                mac_clear = (t_w == '0);
                cap       = (t_w == '0) && (j_w != '0);
                j_prev    = j_w - IDX_W'(1);
                step_d    = step_q + ADDR_W'(1);
                if (step_q == RUN_LAST) begin
                    state_d = DRAIN;
                    step_d  = '0;
                end
            end
            DRAIN: begin
                busy   = 1'b1;
                cap    = (step_q == '0);
                j_prev = IDX_W'(N - 1);
                step_d = step_q + ADDR_W'(1);
                if (step_q == DRAIN_LAST) begin
                    state_d = DONE;
                    step_d  = '0;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clock_count = cnt_q;

    matmul_wr_scheduler u_wr_sched (
        .clk       (clk),
        .reset     (reset),
        .cap_i     (cap),
        .j_prev_i  (j_prev),
        .wr_en_o   (wr_en),
        .wr_sel_o  (wr_sel),
        .wr_addr_o (wr_addr)
    );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a behavioural MAC/buffer/RAM datapath driven by the
// sequencer, with a scoreboard of expected writes built from a software matrix product.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy, done, mac_en, mac_clear, cap, wr_en;
    logic [IDX_W-1:0]  a_idx, wr_sel;
    logic [ADDR_W-1:0] b_addr, wr_addr;
    logic [CNT_W-1:0]  clock_count;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mac_en      (mac_en),
        .mac_clear   (mac_clear),
        .a_idx       (a_idx),
        .b_addr      (b_addr),
        .cap         (cap),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .clock_count (clock_count)
    );

    typedef struct {
        int addr;
        int data;
        int cnt;
    } wr_t;

    logic signed [7:0] mat_a [N*N];
    logic signed [7:0] mat_b [N*N];
    int  acc  [N];
    int  rbuf [N];
    int  ram  [N*N];
    wr_t wr_log [$];
    wr_t exp_q  [$];
    int  clr_log  [$];
    int  cap_log  [$];
    int  done_log [$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Behavioural datapath: MAC lanes, capture buffer and result RAM.
    always @(posedge clk) begin
        if (mac_en) begin
            for (int i = 0; i < N; i++) begin
                if (mac_clear)
                    acc[i] <= int'(mat_a[i*N + int'(a_idx)]) * int'(mat_b[b_addr]);
                else
                    acc[i] <= acc[i] + int'(mat_a[i*N + int'(a_idx)]) * int'(mat_b[b_addr]);
            end
        end
        if (cap) begin
            for (int i = 0; i < N; i++) rbuf[i] <= acc[i];
        end
        if (wr_en) ram[wr_addr] <= rbuf[wr_sel];
    end

    // Event logger: records writes and control pulses with the cycle count they occur at.
    always @(negedge clk) begin
        wr_t w;
        if (wr_en) begin
            w.addr = int'(wr_addr);
            w.data = rbuf[wr_sel];
            w.cnt  = int'(clock_count);
            wr_log.push_back(w);
        end
        if (mac_clear) clr_log.push_back(int'(clock_count));
        if (cap)       cap_log.push_back(int'(clock_count));
        if (done)      done_log.push_back(int'(clock_count));
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // mode 0: A=I, B=8r+c; mode 1: all -128; mode 2: random. Pushes expected writes in order.
    task automatic prepare(input int mode, input bit refill);
        wr_t w;
        int  s;
        if (refill) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    case (mode)
                        0: begin
                            mat_a[r*N+c] = (r == c) ? 8'sd1 : 8'sd0;
                            mat_b[r*N+c] = 8'(r*8 + c);
                        end
                        1: begin
                            mat_a[r*N+c] = -8'sd128;
                            mat_b[r*N+c] = -8'sd128;
                        end
                        default: begin
                            mat_a[r*N+c] = 8'($urandom_range(0, 255));
                            mat_b[r*N+c] = 8'($urandom_range(0, 255));
                        end
                    endcase
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                s = 0;
                for (int t = 0; t < N; t++) s += int'(mat_a[k*N+t]) * int'(mat_b[t*N+j]);
                w.addr = k*N + j;
                w.data = s;
                w.cnt  = 9 + j*N + k;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, mac_en, mac_clear, cap, wr_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {busy, done, mac_en, mac_clear, cap, wr_en});
        end
        n_checks++;
        if (a_idx !== '0 || b_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_idx: a_idx=%0d b_addr=%0d want 0", a_idx, b_addr);
        end
        n_checks++;
        if (wr_sel !== '0 || wr_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_wr: wr_sel=%0d wr_addr=%0d want 0", wr_sel, wr_addr);
        end
        n_checks++;
        if (clock_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", clock_count);
        end
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || clock_count !== '0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b count=%0d want 0/0", busy, clock_count);
        end
    endtask

    task automatic test_identity;
        int  bw, bc, bp, bd, n;
        bit  seen;
        wr_t e;
        bw = wr_log.size(); bc = clr_log.size(); bp = cap_log.size(); bd = done_log.size();
        prepare(0, 1'b1);
        pulse_start();
        wait_done(seen);
        n_checks++;
        if (!seen || clock_count !== CNT_W'(73)) begin
            n_fail++;
            $display("FAIL id_done_count: seen=%b count=%0d want 73", seen, clock_count);
        end
        repeat (3) tick();
        n = wr_log.size() - bw;
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL id_write_total: got %0d want 64", n);
        end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (wr_log[bw+i].addr != e.addr || wr_log[bw+i].data != e.data || wr_log[bw+i].cnt != e.cnt) begin
                n_fail++;
                $display("FAIL id_write[%0d]: addr=%0d data=%0d cnt=%0d want %0d/%0d/%0d", i,
                         wr_log[bw+i].addr, wr_log[bw+i].data, wr_log[bw+i].cnt, e.addr, e.data, e.cnt);
            end
        end
        exp_q.delete();
        for (int i = 0; i < N*N; i++) begin
            n_checks++;
            if (ram[i] != int'(mat_b[i])) begin
                n_fail++;
                $display("FAIL id_ram[%0d]: got %0d want %0d", i, ram[i], int'(mat_b[i]));
            end
        end
        n_checks++;
        if (clr_log.size() - bc != N) begin
            n_fail++;
            $display("FAIL mac_clear_total: got %0d want %0d", clr_log.size() - bc, N);
        end
        for (int i = 0; i < N && bc + i < clr_log.size(); i++) begin
            n_checks++;
            if (clr_log[bc+i] != N*i) begin
                n_fail++;
                $display("FAIL mac_clear_at[%0d]: got %0d want %0d", i, clr_log[bc+i], N*i);
            end
        end
        n_checks++;
        if (cap_log.size() - bp != N) begin
            n_fail++;
            $display("FAIL cap_total: got %0d want %0d", cap_log.size() - bp, N);
        end
        for (int i = 0; i < N && bp + i < cap_log.size(); i++) begin
            n_checks++;
            if (cap_log[bp+i] != N*(i+1)) begin
                n_fail++;
                $display("FAIL cap_at[%0d]: got %0d want %0d", i, cap_log[bp+i], N*(i+1));
            end
        end
        n_checks++;
        if (done_log.size() - bd != 1) begin
            n_fail++;
            $display("FAIL id_done_pulses: got %0d want 1", done_log.size() - bd);
        end
    endtask

    task automatic test_overflow;
        int  bw, n;
        bit  seen;
        wr_t e;
        bw = wr_log.size();
        prepare(1, 1'b1);
        pulse_start();
        wait_done(seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ovf_done: done not seen within budget, count=%0d", clock_count);
        end
        repeat (3) tick();
        n = wr_log.size() - bw;
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL ovf_write_total: got %0d want 64", n);
        end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (wr_log[bw+i].addr != e.addr || wr_log[bw+i].data != 131072) begin
                n_fail++;
                $display("FAIL ovf_write[%0d]: addr=%0d data=%0d want %0d/131072", i,
                         wr_log[bw+i].addr, wr_log[bw+i].data, e.addr);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_ignore_start;
        int  bw, bd, n;
        bit  seen;
        wr_t e;
        bw = wr_log.size(); bd = done_log.size();
        prepare(2, 1'b1);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            start = busy && (clock_count == CNT_W'(5) || clock_count == CNT_W'(40));
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        n_checks++;
        if (!seen || clock_count !== CNT_W'(73)) begin
            n_fail++;
            $display("FAIL ign_done_count: seen=%b count=%0d want 73", seen, clock_count);
        end
        repeat (3) tick();
        n = wr_log.size() - bw;
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL ign_write_total: got %0d want 64", n);
        end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (wr_log[bw+i].addr != e.addr || wr_log[bw+i].data != e.data || wr_log[bw+i].cnt != e.cnt) begin
                n_fail++;
                $display("FAIL ign_write[%0d]: addr=%0d data=%0d cnt=%0d want %0d/%0d/%0d", i,
                         wr_log[bw+i].addr, wr_log[bw+i].data, wr_log[bw+i].cnt, e.addr, e.data, e.cnt);
            end
        end
        exp_q.delete();
        n_checks++;
        if (done_log.size() - bd != 1) begin
            n_fail++;
            $display("FAIL ign_done_pulses: got %0d want 1", done_log.size() - bd);
        end
    endtask

    task automatic test_abort;
        int  bw, bd, n;
        bit  hit, seen;
        wr_t e;
        bw = wr_log.size(); bd = done_log.size();
        prepare(2, 1'b1);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (clock_count == CNT_W'(30)) hit = 1'b1;
            else tick();
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_reach30: count=%0d want 30", clock_count);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, mac_en, mac_clear, cap, wr_en} !== 6'b0 || clock_count !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: flags=%b count=%0d want 000000/0",
                     {busy, done, mac_en, mac_clear, cap, wr_en}, clock_count);
        end
        reset = 1'b0;
        repeat (20) tick();
        n = wr_log.size() - bw;
        n_checks++;
        if (n != 22) begin
            n_fail++;
            $display("FAIL abort_write_total: got %0d want 22", n);
        end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (wr_log[bw+i].addr != e.addr || wr_log[bw+i].data != e.data) begin
                n_fail++;
                $display("FAIL abort_write[%0d]: addr=%0d data=%0d want %0d/%0d", i,
                         wr_log[bw+i].addr, wr_log[bw+i].data, e.addr, e.data);
            end
        end
        exp_q.delete();
        n_checks++;
        if (done_log.size() != bd || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: done_pulses=%0d busy=%b want 0/0", done_log.size() - bd, busy);
        end
        // fresh run after the abort
        bw = wr_log.size();
        prepare(2, 1'b1);
        pulse_start();
        wait_done(seen);
        n_checks++;
        if (!seen || clock_count !== CNT_W'(73)) begin
            n_fail++;
            $display("FAIL rerun_done_count: seen=%b count=%0d want 73", seen, clock_count);
        end
        repeat (3) tick();
        n = wr_log.size() - bw;
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL rerun_write_total: got %0d want 64", n);
        end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (wr_log[bw+i].addr != e.addr || wr_log[bw+i].data != e.data || wr_log[bw+i].cnt != e.cnt) begin
                n_fail++;
                $display("FAIL rerun_write[%0d]: addr=%0d data=%0d cnt=%0d want %0d/%0d/%0d", i,
                         wr_log[bw+i].addr, wr_log[bw+i].data, wr_log[bw+i].cnt, e.addr, e.data, e.cnt);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        int  bw, bd, n;
        bit  seen1, seen2;
        wr_t e;
        bw = wr_log.size(); bd = done_log.size();
        prepare(2, 1'b1);
        prepare(2, 1'b0);
        start = 1'b1;
        tick();
        wait_done(seen1);
        n_checks++;
        if (!seen1) begin
            n_fail++;
            $display("FAIL b2b_done1: done not seen within budget, count=%0d", clock_count);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b want 0/0", busy, done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || clock_count !== '0 || mac_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b count=%0d mac_clear=%b want 1/0/1", busy, clock_count, mac_clear);
        end
        start = 1'b0;
        wait_done(seen2);
        n_checks++;
        if (!seen2 || clock_count !== CNT_W'(73)) begin
            n_fail++;
            $display("FAIL b2b_done2: seen=%b count=%0d want 73", seen2, clock_count);
        end
        repeat (3) tick();
        n = wr_log.size() - bw;
        n_checks++;
        if (n != 128) begin
            n_fail++;
            $display("FAIL b2b_write_total: got %0d want 128", n);
        end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (wr_log[bw+i].addr != e.addr || wr_log[bw+i].data != e.data || wr_log[bw+i].cnt != e.cnt) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: addr=%0d data=%0d cnt=%0d want %0d/%0d/%0d", i,
                         wr_log[bw+i].addr, wr_log[bw+i].data, wr_log[bw+i].cnt, e.addr, e.data, e.cnt);
            end
        end
        exp_q.delete();
        n_checks++;
        if (done_log.size() - bd != 2) begin
            n_fail++;
            $display("FAIL b2b_done_pulses: got %0d want 2", done_log.size() - bd);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_identity();
        test_overflow();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
